// File: rtl/noc_credit_link_port.sv
// noc_credit_link_port: valid/ready to valid/yummy credit-link endpoint, TX credit counter plus RX FWFT FIFO
module noc_credit_link_port #(
    parameter int WIDTH   = 64,
    parameter int CREDITS = 4,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [WIDTH-1:0]             link_out,
    output logic                         link_vld_out,
    input  logic                         link_yummy_in,
    input  logic [WIDTH-1:0]             link_in,
    input  logic                         link_vld_in,
    output logic                         link_yummy_out,
    output logic [WIDTH-1:0]             rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         cred_err,
    output logic                         rx_ovf
);
    localparam int CW = $clog2(CREDITS+1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

    logic             tx_fire, pop, push, full;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [OW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];

    assign tx_ready = credit_cnt != '0;
    assign tx_fire  = tx_valid & tx_ready;
    assign rx_valid = count != '0;
    assign rx_data  = mem[rd_ptr];
    assign full     = count == OW'(DEPTH);
    assign pop      = rx_valid & rx_ready;
    // a pop on a full FIFO frees the slot the simultaneous push lands in
    assign push     = link_vld_in & (!full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt   <= CRED_MAX;
            link_vld_out <= 1'b0;
            link_out     <= '0;
            cred_err     <= 1'b0;
        end else begin
            link_vld_out <= tx_fire;
            link_out     <= tx_fire ? tx_data : link_out;
            if (tx_fire && !link_yummy_in)
                credit_cnt <= credit_cnt - CW'(1);
            else if (link_yummy_in && !tx_fire && credit_cnt != CRED_MAX)
                credit_cnt <= credit_cnt + CW'(1);
            if (link_yummy_in && !tx_fire && credit_cnt == CRED_MAX)
                cred_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            rx_ovf         <= 1'b0;
            link_yummy_out <= 1'b0;
        end else begin
            rd_ptr         <= pop ? (rd_ptr == PTR_LAST ? '0 : rd_ptr + PW'(1)) : rd_ptr;
            wr_ptr         <= push ? (wr_ptr == PTR_LAST ? '0 : wr_ptr + PW'(1)) : wr_ptr;
            count          <= count + OW'(push) - OW'(pop);
            rx_ovf         <= rx_ovf | (link_vld_in & full & !pop);
            link_yummy_out <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= link_in;
    end
endmodule

// File: tb/tb_noc_credit_link_port.sv
// tb_noc_credit_link_port: directed and randomized checks against a queue-based reference model
module tb_noc_credit_link_port;
    localparam int W  = 16;
    localparam int CR = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(CR+1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  tx_data, link_out, link_in, rx_data;
    logic          tx_valid, tx_ready, link_vld_out, link_yummy_in, link_vld_in;
    logic          link_yummy_out, rx_valid, rx_ready, cred_err, rx_ovf;
    logic [CW-1:0] credit_cnt;

    always #5 clk = ~clk;

    noc_credit_link_port #(.WIDTH(W), .CREDITS(CR), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .link_out(link_out), .link_vld_out(link_vld_out), .link_yummy_in(link_yummy_in),
        .link_in(link_in), .link_vld_in(link_vld_in), .link_yummy_out(link_yummy_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .credit_cnt(credit_cnt),
        .cred_err(cred_err), .rx_ovf(rx_ovf)
    );

    int checks = 0;
    int errors = 0;

    int         m_cred;
    logic [W-1:0] m_q[$];
    logic       m_vld, m_yum, m_cerr, m_ovf;
    logic [W-1:0] m_out;

    task automatic model_reset();
        m_cred = CR; m_q.delete(); m_vld = 0; m_yum = 0; m_cerr = 0; m_ovf = 0; m_out = '0;
    endtask

    task automatic idle();
        tx_valid = 0; link_yummy_in = 0; link_vld_in = 0; rx_ready = 0;
        tx_data = W'($urandom); link_in = W'($urandom);
    endtask

    // advance the reference model by one cycle with the present inputs, then clock the DUT
    task automatic step();
        bit fire, pop;
        fire = tx_valid && m_cred > 0;
        pop  = rx_ready && m_q.size() > 0;
        m_vld = fire;
        if (fire) m_out = tx_data;
        if (link_yummy_in && !fire && m_cred == CR) m_cerr = 1;
        else m_cred = m_cred - int'(fire) + int'(link_yummy_in);
        if (pop) void'(m_q.pop_front());
        if (link_vld_in) begin
            if (m_q.size() < D) m_q.push_back(link_in);
            else m_ovf = 1;
        end
        m_yum = pop;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1; model_reset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({credit_cnt, tx_ready, link_vld_out, link_out, link_yummy_out, rx_valid, cred_err, rx_ovf}
            !== {CW'(CR), 1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d rdy=%b vld=%b out=%h yum=%b rxv=%b cerr=%b ovf=%b, need cnt=%0d rdy=1 rest 0",
                     credit_cnt, tx_ready, link_vld_out, link_out, link_yummy_out, rx_valid, cred_err, rx_ovf, CR);
        end
    endtask

    task automatic test_tx_burst();
        logic [5:0] seq;
        idle(); tx_valid = 1;
        for (int i = 0; i < 6; i++) begin
            tx_data = W'($urandom);
            step();
            seq[i] = link_vld_out;
            checks++;
            if (link_out !== m_out) begin
                errors++; $display("FAIL burst_data[%0d]: got %h need %h", i, link_out, m_out);
            end
        end
        checks++;
        if (seq !== 6'b001111) begin
            errors++; $display("FAIL burst_pulses: got %b need 001111", seq);
        end
        checks++;
        if ({tx_ready, credit_cnt} !== {1'b0, CW'(0)}) begin
            errors++; $display("FAIL burst_exhausted: rdy=%b cnt=%0d need rdy=0 cnt=0", tx_ready, credit_cnt);
        end
    endtask

    task automatic test_yummy();
        link_yummy_in = 1; step(); link_yummy_in = 0;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL yummy_wakes_ready: got %b need 1", tx_ready);
        end
        tx_data = 16'h5EED; step();
        checks++;
        if ({link_vld_out, link_out, credit_cnt} !== {1'b1, 16'h5EED, CW'(0)}) begin
            errors++; $display("FAIL yummy_send: vld=%b out=%h cnt=%0d need 1 5eed 0", link_vld_out, link_out, credit_cnt);
        end
        tx_valid = 0; link_yummy_in = 1; step(); step();
        tx_valid = 1; step();
        checks++;
        if ({link_vld_out, credit_cnt} !== {1'b1, CW'(2)}) begin
            errors++; $display("FAIL fire_plus_yummy: vld=%b cnt=%0d need 1 2", link_vld_out, credit_cnt);
        end
        idle();
    endtask

    task automatic test_cred_err();
        link_yummy_in = 1; step(); step();
        checks++;
        if ({cred_err, credit_cnt} !== {1'b0, CW'(CR)}) begin
            errors++; $display("FAIL cred_full: err=%b cnt=%0d need 0 %0d", cred_err, credit_cnt, CR);
        end
        step(); link_yummy_in = 0; step();
        checks++;
        if ({cred_err, credit_cnt} !== {1'b1, CW'(CR)}) begin
            errors++; $display("FAIL cred_err_sticky: err=%b cnt=%0d need 1 %0d", cred_err, credit_cnt, CR);
        end
    endtask

    task automatic test_rx_order();
        logic [W-1:0] v[3] = '{16'hA1, 16'hA2, 16'hA3};
        idle();
        link_vld_in = 1;
        for (int i = 0; i < 3; i++) begin
            link_in = v[i]; step();
            if (i == 0) begin
                checks++;
                if ({rx_valid, rx_data} !== {1'b1, 16'hA1}) begin
                    errors++; $display("FAIL rx_first_latency: valid=%b data=%h need 1 a1", rx_valid, rx_data);
                end
            end
        end
        link_vld_in = 0; rx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rx_valid, rx_data, link_yummy_out} !== {1'b1, v[i], i != 0}) begin
                errors++; $display("FAIL rx_pop_head[%0d]: valid=%b data=%h yum=%b need 1 %h %b", i, rx_valid, rx_data, link_yummy_out, v[i], i != 0);
            end
            step();
            checks++;
            if (link_yummy_out !== 1'b1) begin
                errors++; $display("FAIL rx_yummy_pulse[%0d]: got %b need 1", i, link_yummy_out);
            end
        end
        step();
        checks++;
        if ({rx_valid, link_yummy_out} !== 2'b00) begin
            errors++; $display("FAIL rx_drained: valid=%b yum=%b need 0 0", rx_valid, link_yummy_out);
        end
        idle();
    endtask

    task automatic test_rx_full();
        logic [W-1:0] exp[4] = '{16'hA2, 16'hA3, 16'hA4, 16'hB5};
        idle(); link_vld_in = 1;
        for (int i = 0; i < 4; i++) begin
            link_in = W'(16'hA1 + i); step();
        end
        link_in = 16'hB5; rx_ready = 1; step();
        checks++;
        if ({rx_ovf, rx_data} !== {1'b0, 16'hA2}) begin
            errors++; $display("FAIL full_push_pop: ovf=%b head=%h need 0 a2", rx_ovf, rx_data);
        end
        link_in = 16'hB6; rx_ready = 0; step();
        link_vld_in = 0; step();
        checks++;
        if (rx_ovf !== 1'b1) begin
            errors++; $display("FAIL full_overflow: ovf=%b need 1", rx_ovf);
        end
        rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rx_valid, rx_data} !== {1'b1, exp[i]} || exp[i] !== m_q[0]) begin
                errors++; $display("FAIL wrap_order[%0d]: valid=%b data=%h need 1 %h", i, rx_valid, rx_data, exp[i]);
            end
            step();
        end
        checks++;
        if ({rx_valid, rx_ovf} !== 2'b01) begin
            errors++; $display("FAIL wrap_drained: valid=%b ovf=%b need 0 1", rx_valid, rx_ovf);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tx_valid = 1; link_vld_in = 1;
        for (int i = 0; i < 3; i++) begin
            tx_data = W'($urandom); link_in = W'($urandom); step();
        end
        checks++;
        if ({credit_cnt, rx_valid, link_vld_out} !== {CW'(1), 1'b1, 1'b1}) begin
            errors++; $display("FAIL pre_reset_state: cnt=%0d rxv=%b vld=%b need 1 1 1", credit_cnt, rx_valid, link_vld_out);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({credit_cnt, rx_valid, link_vld_out, link_out, link_yummy_out} !== {CW'(CR), 1'b0, 1'b0, W'(0), 1'b0}) begin
            errors++; $display("FAIL async_reset: cnt=%0d rxv=%b vld=%b out=%h yum=%b need %0d 0 0 0 0",
                               credit_cnt, rx_valid, link_vld_out, link_out, link_yummy_out, CR);
        end
        model_reset(); idle();
        @(posedge clk); #1;
        rst = 0;
        step();
        checks++;
        if ({credit_cnt, rx_valid} !== {CW'(CR), 1'b0}) begin
            errors++; $display("FAIL after_reset: cnt=%0d rxv=%b need %0d 0", credit_cnt, rx_valid, CR);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] dm, em;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            tx_valid      = $urandom_range(0, 1) == 1;
            tx_data       = W'($urandom);
            link_yummy_in = $urandom_range(0, 2) == 0;
            link_vld_in   = $urandom_range(0, 1) == 1;
            link_in       = W'($urandom);
            rx_ready      = $urandom_range(0, 2) != 0;
            dm = rx_valid ? rx_data : '0;
            em = m_q.size() > 0 ? m_q[0] : '0;
            checks++;
            if ({tx_ready, credit_cnt, rx_valid, dm} !== {m_cred > 0, CW'(m_cred), m_q.size() > 0, em}) begin
                errors++; $display("FAIL rand_comb[%0d]: rdy=%b cnt=%0d rxv=%b data=%h need %b %0d %b %h",
                                   c, tx_ready, credit_cnt, rx_valid, dm, m_cred > 0, m_cred, m_q.size() > 0, em);
            end
            step();
            checks++;
            if ({link_vld_out, link_out, link_yummy_out, cred_err, rx_ovf} !== {m_vld, m_out, m_yum, m_cerr, m_ovf}) begin
                errors++; $display("FAIL rand_reg[%0d]: vld=%b out=%h yum=%b cerr=%b ovf=%b need %b %h %b %b %b",
                                   c, link_vld_out, link_out, link_yummy_out, cred_err, rx_ovf, m_vld, m_out, m_yum, m_cerr, m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        #3;
        test_reset();
        test_tx_burst();
        test_yummy();
        test_cred_err();
        test_rx_order();
        test_rx_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
